bus_master_port: RTL and testbench
==================================

# bus_master_port

Initiator-side endpoint of the barq/bagd handshake bus: accepts one local read/write command, requests the bus and waits for the grant and `target_ready`. It then drives `address_valid` and completes on `data_strobe`, returning the read data or an error to the local logic. One instance sits between each local controller and its requester/grant pair on the shared bus arbiter. It enforces its own timeout and detects a lost grant (the arbiter aborted the cycle).

## Interface
- `ADDR_WIDTH`, 16, bus address width
- `DATA_WIDTH`, 16, bus data width
- `TIMEOUT_CLKS`, 32, max cycles from `barq_o` assertion to `data_strobe_i`; must be >= 4
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid_i`  in  1  local command valid
- `req_ready_o`  out  1  command accepted when `req_valid_i & req_ready_o`
- `req_write_i`  in  1  1 = write, 0 = read
- `req_addr_i`  in  ADDR_WIDTH  command address
- `req_wdata_i`  in  DATA_WIDTH  write data
- `rsp_valid_o`  out  1  one-cycle completion pulse
- `rsp_error_o`  out  1  qualifies `rsp_valid_o`: timeout or lost grant
- `rsp_rdata_o`  out  DATA_WIDTH  read data, held until next response
- `barq_o`  out  1  bus request to arbiter
- `bagd_i`  in  1  bus grant from arbiter
- `target_ready_i`  in  1  target ready from arbiter
- `address_valid_o`  out  1  address phase valid
- `data_strobe_i`  in  1  transfer strobe from arbiter
- `write_o`, `addr_o`, `wdata_o`  out  1/ADDR_WIDTH/DATA_WIDTH  bus command, valid while `barq_o`=1
- `rdata_i`  in  DATA_WIDTH  sampled on `data_strobe_i`

## Operation
- States: IDLE, REQ, WAIT_RDY, ADDR, DONE.
- IDLE: `req_ready_o`=1. On accept, latch write/addr/wdata into command register, go REQ. `barq_o` is registered and rises on the accept edge.
- REQ: hold `barq_o`=1. On `bagd_i`=1 go WAIT_RDY.
- WAIT_RDY: on `bagd_i & target_ready_i`, set `address_valid_o`=1, go ADDR.
- ADDR: hold `address_valid_o`. On `data_strobe_i`: capture `rdata_i` (reads only; writes leave `rsp_rdata_o` unchanged), clear `barq_o` and `address_valid_o`, pulse `rsp_valid_o` with `rsp_error_o`=0, go DONE.
- Lost grant: `bagd_i`=0 while in WAIT_RDY or ADDR without `data_strobe_i` that cycle → error response, go DONE.
- Timeout: counter width `$clog2(TIMEOUT_CLKS+1)`, cleared on accept, increments each cycle in REQ/WAIT_RDY/ADDR, saturating. Reaching `TIMEOUT_CLKS` → error response, go DONE.
- Priority when events coincide in one cycle: `data_strobe_i` > lost grant > timeout. A strobe always completes successfully.
- DONE: all bus outputs 0, `req_ready_o`=0, for exactly one cycle, then IDLE. This guarantees `barq_o` and `address_valid_o` are low for at least one arbiter sample, so the arbiter re-latches requests and detects a fresh `address_valid` rising edge.
- `data_strobe_i`, `target_ready_i` and `bagd_i` are ignored in IDLE and DONE. `data_strobe_i` in REQ/WAIT_RDY is ignored.
- `write_o`/`addr_o`/`wdata_o` are driven from the command register and read 0 in IDLE/DONE.

## Timing
- Reset values: `req_ready_o`=0 during reset and 1 from the first edge after release (IDLE). All other outputs 0. Reset mid-transaction drops `barq_o` and `address_valid_o` asynchronously and emits no response.
- Accept at edge N → `barq_o`=1 after edge N.
- First cycle with `bagd_i`=1 at edge G → WAIT_RDY. `target_ready_i` seen at edge T → `address_valid_o`=1 after T.
- `data_strobe_i` seen at edge S → after S: `rsp_valid_o`=1, `barq_o`=0, `address_valid_o`=0. After S+1: `req_ready_o`=1.
- Minimum back-to-back command period is 2 cycles plus bus latency. `barq_o` is low for at least 2 edges between transactions.
- Error response latency: 1 cycle after the detecting edge.

## Test plan
- Read: addr 0x0012; `bagd_i` 2 cycles after `barq_o`, `target_ready_i` next cycle, `data_strobe_i` 3 cycles after `address_valid_o` with `rdata_i`=0xBEEF → `rsp_valid_o` 1 cycle, `rsp_error_o`=0, `rsp_rdata_o`=0xBEEF, `barq_o` low for ≥2 edges.
- Write: addr 0x0100, wdata 0x5A5A → `write_o`=1, `addr_o`/`wdata_o` stable from `barq_o` rise to strobe, `rsp_rdata_o` unchanged.
- Timeout: `TIMEOUT_CLKS`=8, `bagd_i` never asserted → `rsp_valid_o` & `rsp_error_o` 9 cycles after accept, `barq_o` falls the same edge.
- Lost grant: `bagd_i` drops in ADDR with no strobe → error response next cycle, `address_valid_o`=0.
- Coincidence: `data_strobe_i` on the same edge the timeout counter reaches `TIMEOUT_CLKS` → success response, data captured.
- Reset: assert `rst_n`=0 while in ADDR → `barq_o`, `address_valid_o` 0 immediately, no `rsp_valid_o`; after release, a new read completes normally.

Source files
------------

// File: rtl/bus_master_port_if.sv
// Local command/response and arbiter-side signals of one bus_master_port.
// The master modport is the endpoint's view; slave is the view of the local logic and arbiter.
interface bus_master_port_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_write_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  rsp_valid_o;
    logic                  rsp_error_o;
    logic [DATA_WIDTH-1:0] rsp_rdata_o;
    logic                  barq_o;
    logic                  bagd_i;
    logic                  target_ready_i;
    logic                  address_valid_o;
    logic                  data_strobe_i;
    logic                  write_o;
    logic [ADDR_WIDTH-1:0] addr_o;
    logic [DATA_WIDTH-1:0] wdata_o;
    logic [DATA_WIDTH-1:0] rdata_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        input  bagd_i, target_ready_i, data_strobe_i, rdata_i,
        output req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o,
        output barq_o, address_valid_o, write_o, addr_o, wdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
        output bagd_i, target_ready_i, data_strobe_i, rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_error_o, rsp_rdata_o,
        input  barq_o, address_valid_o, write_o, addr_o, wdata_o
    );
endinterface

// File: rtl/bus_master_port.sv
// Initiator endpoint of the barq/bagd handshake bus: runs one local command at a time
// and returns read data, or an error on timeout or lost grant.
module bus_master_port #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 16,
    parameter int TIMEOUT_CLKS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    bus_master_port_if.master bus
);
    localparam int               CNT_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_RDY, ADDR, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic                  cmd_write_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DATA_WIDTH-1:0] cmd_wdata_q;
    logic                  rsp_valid_q;
    logic                  rsp_error_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  accept, busy, timeout, done_ok, done_err;

    assign busy    = (state_q == REQ) || (state_q == WAIT_RDY) || (state_q == ADDR);
    assign accept  = (state_q == IDLE) && bus.req_valid_i;
    assign timeout = (cnt_q == CNT_MAX);

    // Strobe beats lost grant, lost grant beats timeout; timeout also beats a pending advance.
    always_comb begin
        state_d  = state_q;
        done_ok  = 1'b0;
        done_err = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = REQ;
            REQ: begin
                if (timeout)         done_err = 1'b1;
                else if (bus.bagd_i) state_d  = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!bus.bagd_i || timeout)  done_err = 1'b1;
                else if (bus.target_ready_i) state_d  = ADDR;
            end
            ADDR: begin
                if (bus.data_strobe_i)              done_ok  = 1'b1;
                else if (!bus.bagd_i || timeout)    done_err = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (done_ok || done_err) state_d = DONE;
    end

    // Reset parks in DONE so req_ready_o stays low until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DONE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= done_ok || done_err;
            rsp_error_q <= done_err;
            if (done_ok && !cmd_write_q) rsp_rdata_q <= bus.rdata_i;
            if (accept) begin
                cnt_q       <= '0;
                cmd_write_q <= bus.req_write_i;
                cmd_addr_q  <= bus.req_addr_i;
                cmd_wdata_q <= bus.req_wdata_i;
            end else if (busy && !timeout) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.req_ready_o     = (state_q == IDLE);
    assign bus.barq_o          = busy;
    assign bus.address_valid_o = (state_q == ADDR);
    assign bus.rsp_valid_o     = rsp_valid_q;
    assign bus.rsp_error_o     = rsp_error_q;
    assign bus.rsp_rdata_o     = rsp_rdata_q;
    assign bus.write_o         = busy && cmd_write_q;
    assign bus.addr_o          = busy ? cmd_addr_q  : '0;
    assign bus.wdata_o         = busy ? cmd_wdata_q : '0;
endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: directed vector table, reset-in-flight sequence and
// randomized transactions against a closed-form model of completion time.
module tb_bus_master_port;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

    bus_master_port #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Edge indices are counted from the accept edge (0). g: first edge bagd seen,
    // t: first edge target_ready seen, s: strobe edge, d: bagd drop edge (0 = none),
    // e: edge at which the response is registered, err: error response expected.
    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] wd;
        logic [15:0] rd;
        int          g;
        int          t;
        int          s;
        int          d;
        int          e;
        logic        err;
    } vec_t;

    vec_t        tbl [9];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] last_rdata;
    bit          noise_en;

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", what, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] status();
        return {bus.barq_o, bus.address_valid_o, bus.rsp_valid_o, bus.rsp_error_o, bus.req_ready_o};
    endfunction

    function automatic logic [32:0] cmd_out();
        return {bus.write_o, bus.addr_o, bus.wdata_o};
    endfunction

    // Earliest of strobe, grant drop and timeout ends the cycle; ties go to the strobe.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r   = v;
        r.e = v.s;
        if (v.d != 0 && v.d < r.e) r.e = v.d;
        if (TO + 1 < r.e)          r.e = TO + 1;
        r.err = (r.e != v.s);
        return r;
    endfunction

    task automatic idle_inputs();
        bus.req_valid_i    = 1'b0;
        bus.req_write_i    = noise_en ? 1'($urandom) : 1'b0;
        bus.req_addr_i     = noise_en ? 16'($urandom) : '0;
        bus.req_wdata_i    = noise_en ? 16'($urandom) : '0;
        bus.bagd_i         = noise_en ? 1'($urandom) : 1'b0;
        bus.target_ready_i = noise_en ? 1'($urandom) : 1'b0;
        bus.data_strobe_i  = noise_en ? 1'($urandom) : 1'b0;
        bus.rdata_i        = noise_en ? 16'($urandom) : '0;
    endtask

    // Inputs to be sampled at edge k of transaction v.
    task automatic drive(input int k, input vec_t v);
        bit idle;
        idle = (k == 0) || (k > v.e);
        idle_inputs();
        bus.req_valid_i = (k == 0);
        if (k == 0) begin
            bus.req_write_i = v.w;
            bus.req_addr_i  = v.a;
            bus.req_wdata_i = v.wd;
        end else begin
            bus.req_write_i = 1'($urandom);
            bus.req_addr_i  = 16'($urandom);
            bus.req_wdata_i = 16'($urandom);
        end
        if (!idle) begin
            bus.bagd_i         = (k >= v.g) && !(v.d != 0 && k >= v.d);
            bus.target_ready_i = (k >= v.t) || (noise_en && k <= v.g && 1'($urandom));
            bus.data_strobe_i  = (k == v.s) || (noise_en && k <= v.t && 1'($urandom));
        end
        if (k == v.s) bus.rdata_i = v.rd;
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        logic [4:0]  st_exp;
        logic [32:0] cmd_exp;
        bit          busy;
        chk({tag, " ready_before"}, 64'(bus.req_ready_o), 64'(1));
        for (int k = 0; k <= v.e + 1; k++) begin
            drive(k, v);
            step();
            busy    = (k < v.e);
            st_exp  = {busy, (k >= v.t && k < v.e), (k == v.e), (k == v.e && v.err), (k == v.e + 1)};
            cmd_exp = busy ? {v.w, v.a, v.wd} : '0;
            if (k == v.e && !v.err && !v.w) last_rdata = v.rd;
            chk($sformatf("%s k=%0d status{barq,av,rv,re,rdy}", tag, k), 64'(status()), 64'(st_exp));
            chk($sformatf("%s k=%0d cmd{w,addr,wdata}", tag, k), 64'(cmd_out()), 64'(cmd_exp));
            chk($sformatf("%s k=%0d rsp_rdata", tag, k), 64'(bus.rsp_rdata_o), 64'(last_rdata));
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   gap;

        noise_en   = 1'b0;
        last_rdata = '0;
        rst_n      = 1'b0;
        idle_inputs();

        tbl[0] = '{w:1'b0, a:16'h0012, wd:16'h0000, rd:16'hBEEF, g:2, t:3, s:6,  d:0, e:6, err:1'b0};
        tbl[1] = '{w:1'b1, a:16'h0100, wd:16'h5A5A, rd:16'h1111, g:1, t:2, s:4,  d:0, e:4, err:1'b0};
        tbl[2] = '{w:1'b0, a:16'h0200, wd:16'h0000, rd:16'h2222, g:20, t:21, s:22, d:0, e:9, err:1'b1};
        tbl[3] = '{w:1'b0, a:16'h0300, wd:16'h0000, rd:16'h3333, g:1, t:2, s:10, d:4, e:4, err:1'b1};
        tbl[4] = '{w:1'b0, a:16'h0400, wd:16'h0000, rd:16'hC0DE, g:1, t:2, s:9,  d:0, e:9, err:1'b0};
        tbl[5] = '{w:1'b0, a:16'h0500, wd:16'h0000, rd:16'h5555, g:2, t:6, s:8,  d:4, e:4, err:1'b1};
        tbl[6] = '{w:1'b0, a:16'h0600, wd:16'h0000, rd:16'h6666, g:1, t:2, s:5,  d:5, e:5, err:1'b0};
        tbl[7] = '{w:1'b1, a:16'h0700, wd:16'hA5A5, rd:16'h7777, g:1, t:2, s:12, d:0, e:9, err:1'b1};
        tbl[8] = '{w:1'b0, a:16'h0800, wd:16'h0000, rd:16'h8888, g:3, t:9, s:10, d:0, e:9, err:1'b1};

        repeat (3) step();
        chk("reset status", 64'(status()), 64'(0));
        chk("reset cmd", 64'(cmd_out()), 64'(0));
        chk("reset rsp_rdata", 64'(bus.rsp_rdata_o), 64'(0));
        rst_n = 1'b1;
        step();
        chk("ready after release", 64'(status()), 64'(5'b00001));

        for (int i = 0; i < 9; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // Reset while the address phase is active.
        v = '{w:1'b0, a:16'h0077, wd:16'h0000, rd:16'h7070, g:1, t:2, s:30, d:0, e:30, err:1'b0};
        for (int k = 0; k <= 3; k++) begin
            drive(k, v);
            step();
        end
        chk("inflight before reset", 64'(status()), 64'(5'b11000));
        #2 rst_n = 1'b0;
        #1;
        chk("async reset drop", 64'(status()), 64'(0));
        chk("async reset cmd", 64'(cmd_out()), 64'(0));
        idle_inputs();
        repeat (2) begin
            step();
            chk("no response in reset", 64'(status()), 64'(0));
        end
        last_rdata = '0;
        chk("rsp_rdata cleared by reset", 64'(bus.rsp_rdata_o), 64'(last_rdata));
        rst_n = 1'b1;
        step();
        chk("ready after second release", 64'(status()), 64'(5'b00001));
        run_txn("post_reset", '{w:1'b0, a:16'h0099, wd:16'h0000, rd:16'h9999, g:1, t:2, s:4, d:0, e:4, err:1'b0});

        noise_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            v.w  = 1'($urandom);
            v.a  = 16'($urandom);
            v.wd = 16'($urandom);
            v.rd = 16'($urandom);
            v.g  = $urandom_range(1, 5);
            v.t  = v.g + $urandom_range(1, 4);
            v.s  = v.t + $urandom_range(1, 5);
            v.d  = ($urandom_range(0, 1) == 1) ? $urandom_range(v.g + 1, v.s + 1) : 0;
            v    = model(v);
            run_txn($sformatf("rnd%0d", i), v);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                idle_inputs();
                step();
                chk($sformatf("rnd%0d gap%0d status", i, j), 64'(status()), 64'(5'b00001));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
